// File: rtl/up_dp_param.sv
// Accumulator-machine datapath: IR, A, PC, program/data RAM, add/sub ALU with carry,
// hardware return stack, registered output port and RAM init port.
module up_dp_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned OPC_W     = 3,
  parameter int unsigned STK_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_i,
  input  logic [ADDR_W-1:0] init_addr_i,
  input  logic [DATA_W-1:0] init_data_i,
  input  logic [DATA_W-1:0] input_i,
  input  logic              ir_load_i,
  input  logic              pc_load_i,
  input  logic              a_load_i,
  input  logic              mem_wr_i,
  input  logic              jmp_mux_i,
  input  logic              mem_inst_i,
  input  logic              sub_i,
  input  logic [1:0]        a_sel_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              out_load_i,
  output logic              a_eq0_o,
  output logic              a_pos_o,
  output logic              c_flag_o,
  output logic [OPC_W-1:0]  ir_o,
  output logic [DATA_W-1:0] output_o,
  output logic              out_valid_o,
  output logic              stk_full_o,
  output logic              stk_empty_o,
  output logic              stk_err_o
);

  localparam int unsigned SpW   = $clog2(STK_DEPTH) + 1;
  localparam int unsigned Depth = 2 ** ADDR_W;

  if (DATA_W < OPC_W + ADDR_W) begin : g_bad_width
    $error("up_dp_param: DATA_W must be >= OPC_W + ADDR_W");
  end
  if (STK_DEPTH < 2 || (STK_DEPTH & (STK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("up_dp_param: STK_DEPTH must be a power of 2 and >= 2");
  end

  logic [DATA_W-1:0] mem [Depth];

  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              stk_err_q, stk_err_d;
  logic [SpW-1:0]    sp_q, sp_d;
  logic [ADDR_W-1:0] stk_q [STK_DEPTH];

  logic              stk_we;
  logic [ADDR_W-1:0] ir_addr, mem_addr, pc_inc, pc_seq, stk_top;
  logic [DATA_W-1:0] mem_rdata, alu_b;
  logic [DATA_W:0]   alu_sum;
  logic [SpW-2:0]    sp_idx, top_idx;
  logic              full, empty, en;

  assign ir_addr   = ir_q[ADDR_W-1:0];
  assign mem_addr  = mem_inst_i ? ir_addr : pc_q;
  assign mem_rdata = mem[mem_addr];
  assign pc_inc    = pc_q + 1'b1;
  assign pc_seq    = jmp_mux_i ? ir_addr : pc_inc;

  // Subtract as A + ~M + 1 so the carry out is the no-borrow flag.
  assign alu_b   = sub_i ? ~mem_rdata : mem_rdata;
  assign alu_sum = {1'b0, a_q} + {1'b0, alu_b} + {{DATA_W{1'b0}}, sub_i};

  assign full    = (sp_q == SpW'(STK_DEPTH));
  assign empty   = (sp_q == '0);
  assign sp_idx  = sp_q[SpW-2:0];
  assign top_idx = sp_idx - 1'b1;
  assign stk_top = stk_q[top_idx];
  assign en      = ~init_i;

  always_comb begin
    ir_d        = ir_q;
    a_d         = a_q;
    pc_d        = pc_q;
    c_d         = c_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    stk_err_d   = stk_err_q;
    sp_d        = sp_q;
    stk_we      = 1'b0;
    if (en) begin
      if (ir_load_i) ir_d = mem_rdata;
      if (a_load_i) begin
        unique case (a_sel_i)
          2'b00: begin
            a_d = alu_sum[DATA_W-1:0];
            c_d = alu_sum[DATA_W];
          end
          2'b01:   a_d = input_i;
          default: a_d = mem_rdata;
        endcase
      end
      if (out_load_i) begin
        out_d       = a_q;
        out_valid_d = 1'b1;
      end
      if (pc_load_i) pc_d = pc_seq;
      if (push_i && pop_i) begin
        stk_err_d = 1'b1;
      end else if (push_i) begin
        if (full) begin
          stk_err_d = 1'b1;
        end else begin
          stk_we = 1'b1;
          sp_d   = sp_q + 1'b1;
        end
      end else if (pop_i && pc_load_i) begin
        if (empty) begin
          pc_d      = '0;
          stk_err_d = 1'b1;
        end else begin
          pc_d = stk_top;
          sp_d = sp_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir_q        <= '0;
      a_q         <= '0;
      pc_q        <= '0;
      c_q         <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      stk_err_q   <= 1'b0;
      sp_q        <= '0;
      for (int i = 0; i < int'(STK_DEPTH); i++) stk_q[i] <= '0;
    end else begin
      ir_q        <= ir_d;
      a_q         <= a_d;
      pc_q        <= pc_d;
      c_q         <= c_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      stk_err_q   <= stk_err_d;
      sp_q        <= sp_d;
      if (stk_we) stk_q[sp_idx] <= pc_inc;
    end
  end

  // RAM has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (init_i) begin
        mem[init_addr_i] <= init_data_i;
      end else if (mem_wr_i) begin
        mem[mem_addr] <= a_q;
      end
    end
  end

  assign a_eq0_o     = (a_q == '0);
  assign a_pos_o     = ~a_q[DATA_W-1];
  assign c_flag_o    = c_q;
  assign ir_o        = ir_q[DATA_W-1 -: OPC_W];
  assign output_o    = out_q;
  assign out_valid_o = out_valid_q;
  assign stk_full_o  = full;
  assign stk_empty_o = empty;
  assign stk_err_o   = stk_err_q;

endmodule

// File: tb/tb_up_dp_param.sv
// Directed self-checking bench for up_dp_param with default parameters.
module tb_up_dp_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0;
  logic [4:0] init_addr = '0;
  logic [7:0] init_data = '0;
  logic [7:0] din = '0;
  logic       ir_load = 0, pc_load = 0, a_load = 0, mem_wr = 0;
  logic       jmp_mux = 0, mem_inst = 0, sub = 0, push = 0, pop = 0, out_load = 0;
  logic [1:0] a_sel = '0;

  logic       a_eq0, a_pos, c_flag, out_valid, stk_full, stk_empty, stk_err;
  logic [2:0] ir;
  logic [7:0] dout;

  int npass = 0;
  int nfail = 0;
  int nchk  = 0;

  up_dp_param #(.DATA_W(8), .ADDR_W(5), .OPC_W(3), .STK_DEPTH(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .init_i      (init),
    .init_addr_i (init_addr),
    .init_data_i (init_data),
    .input_i     (din),
    .ir_load_i   (ir_load),
    .pc_load_i   (pc_load),
    .a_load_i    (a_load),
    .mem_wr_i    (mem_wr),
    .jmp_mux_i   (jmp_mux),
    .mem_inst_i  (mem_inst),
    .sub_i       (sub),
    .a_sel_i     (a_sel),
    .push_i      (push),
    .pop_i       (pop),
    .out_load_i  (out_load),
    .a_eq0_o     (a_eq0),
    .a_pos_o     (a_pos),
    .c_flag_o    (c_flag),
    .ir_o        (ir),
    .output_o    (dout),
    .out_valid_o (out_valid),
    .stk_full_o  (stk_full),
    .stk_empty_o (stk_empty),
    .stk_err_o   (stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ir_load = 0; pc_load = 0; a_load = 0; mem_wr = 0; jmp_mux = 0; mem_inst = 0;
    sub = 0; push = 0; pop = 0; out_load = 0; a_sel = 2'b00; init = 0;
  endtask

  task automatic load_a(input logic [7:0] v);
    idle(); a_load = 1; a_sel = 2'b01; din = v; cyc();
  endtask

  // A <= RAM[PC], used to observe PC.
  task automatic read_pc();
    idle(); a_load = 1; a_sel = 2'b10; mem_inst = 0; cyc();
  endtask

  task automatic check_a(input string tag, input logic [7:0] exp);
    idle(); out_load = 1; cyc(); out_load = 0;
    chk(tag, dout, exp);
    chk({tag, "_valid"}, out_valid, 1'b1);
  endtask

  task automatic ram(input logic [4:0] a, input logic [7:0] d);
    init = 1; init_addr = a; init_data = d; cyc();
  endtask

  initial begin
    #2;
    chk("rst_aeq0", a_eq0, 1'b1);
    chk("rst_apos", a_pos, 1'b1);
    chk("rst_c", c_flag, 1'b0);
    chk("rst_ir", ir, 3'b000);
    chk("rst_out", dout, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_empty", stk_empty, 1'b1);
    chk("rst_full", stk_full, 1'b0);
    chk("rst_err", stk_err, 1'b0);
    cyc();
    rst = 0;

    // Init with every other enable asserted: only the RAM may change.
    idle();
    ir_load = 1; pc_load = 1; a_load = 1; a_sel = 2'b01; din = 8'hFF; out_load = 1; push = 1;
    ram(5'd0, 8'h23); ram(5'd1, 8'h05); ram(5'd2, 8'h07); ram(5'd3, 8'h20);
    ram(5'd7, 8'h54); ram(5'd8, 8'h88); ram(5'd9, 8'h99); ram(5'd20, 8'hA5);
    chk("init_valid", out_valid, 1'b0);
    chk("init_aeq0", a_eq0, 1'b1);
    chk("init_ir", ir, 3'b000);
    chk("init_empty", stk_empty, 1'b1);

    idle(); ir_load = 1; pc_load = 1; cyc();
    chk("fetch_ir", ir, 3'b001);

    load_a(8'hF0);
    chk("ldin_apos", a_pos, 1'b0);
    chk("ldin_aeq0", a_eq0, 1'b0);

    idle(); a_load = 1; a_sel = 2'b00; mem_inst = 1; cyc();
    chk("add_c", c_flag, 1'b1);
    chk("add_apos", a_pos, 1'b1);
    check_a("add_a", 8'h10);

    load_a(8'h10);
    chk("c_hold", c_flag, 1'b1);

    idle(); a_load = 1; a_sel = 2'b00; sub = 1; mem_inst = 1; cyc();
    chk("sub_c", c_flag, 1'b0);
    chk("sub_apos", a_pos, 1'b0);
    check_a("sub_a", 8'hF0);

    // Output captures the pre-edge A while A is reloaded on the same edge.
    load_a(8'h5A);
    idle(); out_load = 1; a_load = 1; a_sel = 2'b01; din = 8'h00; cyc();
    chk("out_5a", dout, 8'h5A);
    chk("out_valid1", out_valid, 1'b1);
    chk("out_aeq0", a_eq0, 1'b1);
    idle(); cyc();
    chk("out_valid0", out_valid, 1'b0);
    chk("out_hold", dout, 8'h5A);

    load_a(8'h3C);
    idle(); mem_wr = 1; mem_inst = 1; cyc();
    load_a(8'h00);
    idle(); a_load = 1; a_sel = 2'b10; mem_inst = 1; cyc();
    check_a("memwr", 8'h3C);

    idle(); pc_load = 1; cyc();
    idle(); ir_load = 1; pc_load = 1; cyc();
    chk("ir_07", ir, 3'b000);
    idle(); pc_load = 1; jmp_mux = 1; cyc();
    idle(); ir_load = 1; cyc();
    chk("ir_54", ir, 3'b010);
    read_pc();
    check_a("pc_7", 8'h54);

    idle(); push = 1; pc_load = 1; jmp_mux = 1; cyc();
    chk("call_empty", stk_empty, 1'b0);
    chk("call_err", stk_err, 1'b0);
    read_pc();
    check_a("call_pc20", 8'hA5);

    idle(); pop = 1; pc_load = 1; cyc();
    chk("ret_empty", stk_empty, 1'b1);
    read_pc();
    check_a("ret_pc8", 8'h88);

    for (int i = 0; i < 3; i++) begin
      idle(); push = 1; cyc();
    end
    chk("push3_full", stk_full, 1'b0);
    idle(); push = 1; cyc();
    chk("push4_full", stk_full, 1'b1);
    chk("push4_err", stk_err, 1'b0);
    idle(); push = 1; cyc();
    chk("push5_full", stk_full, 1'b1);
    chk("push5_err", stk_err, 1'b1);
    idle(); pop = 1; cyc();
    chk("pop_nopc_full", stk_full, 1'b1);
    idle(); pop = 1; pc_load = 1; cyc();
    chk("pop1_full", stk_full, 1'b0);
    read_pc();
    check_a("pop1_pc9", 8'h99);
    for (int i = 0; i < 3; i++) begin
      idle(); pop = 1; pc_load = 1; cyc();
    end
    chk("pop4_empty", stk_empty, 1'b1);
    idle(); pop = 1; pc_load = 1; cyc();
    chk("popempty_err", stk_err, 1'b1);
    read_pc();
    check_a("popempty_pc0", 8'h23);

    // Asynchronous reset in the middle of a cycle with a push pending.
    idle(); push = 1; cyc();
    load_a(8'h77);
    idle(); push = 1; pc_load = 1; jmp_mux = 1;
    #3;
    rst = 1;
    #1;
    chk("arst_empty", stk_empty, 1'b1);
    chk("arst_aeq0", a_eq0, 1'b1);
    chk("arst_ir", ir, 3'b000);
    chk("arst_err", stk_err, 1'b0);
    chk("arst_valid", out_valid, 1'b0);
    idle(); cyc();
    rst = 0;

    idle(); push = 1; pop = 1; pc_load = 1; cyc();
    chk("pushpop_err", stk_err, 1'b1);
    chk("pushpop_empty", stk_empty, 1'b1);
    read_pc();
    check_a("pushpop_pc1", 8'h05);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
